seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PAT_W, default 8, meaning maximum pattern length in bits (2..16).
REQ-002 SHALL have parameter DIGITS, default 2, meaning number of BCD count digits and 7-segment displays (1..4).
REQ-003 SHALL have one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 SHALL have port ena  in  1  sample enable; sig_to_test is consumed only on cycles with ena=1.
REQ-006 SHALL have port sig_to_test  in  1  serial bit under test.
REQ-007 SHALL have port cfg_load  in  1  one-cycle strobe loading cfg_pattern, cfg_len and cfg_overlap.
REQ-008 SHALL have port cfg_pattern  in  PAT_W  target pattern; bit cfg_len-1 is the first bit received, bit 0 the last.
REQ-009 SHALL have port cfg_len  in  $clog2(PAT_W+1)  pattern length.
REQ-010 SHALL have port cfg_overlap  in  1  1 = overlapping matches allowed, 0 = history flushed after each match.
REQ-011 SHALL have port clr_count  in  1  clears the match count and the overflow flag.
REQ-012 SHALL have port z  out  1  one-cycle match pulse.
REQ-013 SHALL have port cfg_err  out  1  one-cycle pulse flagging a rejected configuration.
REQ-014 SHALL have port count  out  4*DIGITS  BCD match count; digit 0 is bits [3:0].
REQ-015 SHALL have port ovf  out  1  sticky count wrap flag.
REQ-016 SHALL have port disp  out  7*DIGITS  active-low segments {g..a} per digit; digit 0 is bits [6:0].

Function
REQ-017 SHALL implement FSM states S_IDLE (unconfigured, input ignored), S_FILL (history holds fewer than len valid bits) and S_MATCH (comparing every sample).
REQ-018 SHALL, on cfg_load with 2<=cfg_len<=PAT_W, latch the configuration, clear the history and fill counter, and enter S_FILL; a sample presented in that cycle is discarded.
REQ-019 SHALL, on cfg_load with cfg_len<2 or cfg_len>PAT_W, pulse cfg_err, enter S_IDLE and keep the previous configuration registers unchanged.
REQ-020 SHALL, on each ena=1 cycle in S_FILL/S_MATCH, shift sig_to_test into history bit 0 and increment the fill counter (saturating at len); S_FILL moves to S_MATCH when the counter reaches len.
REQ-021 SHALL compare history[len-1:0] with pattern[len-1:0] (masked by len) including the sample just shifted, and register z=1 at that same clock edge, so z is high for exactly the following cycle.
REQ-022 SHALL, after a match with overlap=0, clear the history and fill counter and return to S_FILL; with overlap=1 it SHALL stay in S_MATCH.
REQ-023 SHALL hold z=0 on ena=0 cycles and hold all state while ena=0.
REQ-024 SHALL increment count in BCD at the edge that raises z; 10^DIGITS-1 SHALL wrap to 0 and set ovf.
REQ-025 SHALL give clr_count priority over a simultaneous match: count=0 and ovf=0, while z still pulses.
REQ-026 SHALL register disp from count with one cycle of latency; codes 0..9 are the standard active-low digits (0 = 7'b1000000).

Reset
REQ-027 SHALL, while rst=1, force S_IDLE, history=0, pattern=0, len=0, overlap=1, z=0, cfg_err=0, count=0, ovf=0 and every disp digit = 7'b1000000.
REQ-028 SHALL give rst priority over cfg_load, clr_count and ena when they coincide, including in the middle of a pattern.

Configuration
REQ-029 SHALL, with SEQ_DET_BLANK_EN defined, blank leading-zero digits (7'b1111111) above digit 0; without it, all digits SHALL always display.

Structure
REQ-030 SHALL place the FSM state enum, the seven-segment code constants and the blank code in package seq_det_pkg.
REQ-031 SHALL instantiate a sub-module seg7_decode (4-bit BCD in, 7-bit active-low out; non-BCD input gives 7'b0000111) once per digit.

Verification
REQ-032 SHALL cover: pattern 4'b0101, len 4, overlap=1, stream 0,1,0,1,0,1 with ena=1 -> z after the 4th and 6th bits, count=0x02.
REQ-033 SHALL cover: the same stream with overlap=0 -> z after the 4th bit only, count=0x01.
REQ-034 SHALL cover: DIGITS=2, 100 matches -> count=0x00, ovf=1, disp={7'b1000000,7'b1000000}; then clr_count -> ovf=0.
REQ-035 SHALL cover: cfg_len=0 and cfg_len=PAT_W+1 -> cfg_err pulses, no z thereafter until a valid cfg_load.
REQ-036 SHALL cover: rst asserted after 3 of 4 pattern bits -> all reset values of REQ-027; completing the pattern yields no z.
REQ-037 SHALL cover: ena toggled 0/1 between pattern bits -> a match is found exactly as with ena held at 1, and z stays 0 on ena=0 cycles.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and constants for the serial pattern detector.
//   state_t      - detector FSM states
//   SEG_0..SEG_9 - active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//   SEG_BAD      - code shown for a non-BCD nibble
//   SEG_BLANK    - all segments off (leading-zero blanking)
package seq_det_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,  // unconfigured, input ignored
    S_FILL  = 2'd1,  // history holds fewer than len valid bits
    S_MATCH = 2'd2   // history full, compare on every sample
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BAD   = 7'b0000111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD nibble to active-low 7-segment code, purely combinational.
//   bcd [3:0] in  - BCD digit
//   seg [6:0] out - active-low segments {g..a}; 10..15 give SEG_BAD
module seg7_decode
  import seq_det_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BAD;
    endcase
  end

endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-configurable serial pattern detector with a BCD
// match counter and registered 7-segment display.
//   clk, rst     - clock, synchronous active-high reset
//   ena          - sample enable for sig_to_test
//   sig_to_test  - serial input bit
//   cfg_load     - strobe loading cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern  - pattern, bit cfg_len-1 received first
//   cfg_len      - pattern length (2..PAT_W valid)
//   cfg_overlap  - 1: overlapping matches, 0: flush history after a match
//   clr_count    - clears count and ovf
//   z            - one-cycle match pulse
//   cfg_err      - one-cycle pulse on a rejected configuration
//   count        - BCD match count, digit 0 in [3:0]
//   ovf          - sticky count wrap flag
//   disp         - active-low segments per digit, digit 0 in [6:0]
// Build option: SEQ_DET_BLANK_EN blanks leading-zero digits above digit 0.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W  = 8,
  parameter int DIGITS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       sig_to_test,
  input  logic                       cfg_load,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
  input  logic                       cfg_overlap,
  input  logic                       clr_count,
  output logic                       z,
  output logic                       cfg_err,
  output logic [4*DIGITS-1:0]        count,
  output logic                       ovf,
  output logic [7*DIGITS-1:0]        disp
);

  localparam int LW = $clog2(PAT_W+1);
  localparam logic [LW-1:0] LEN_MIN = LW'(2);
  localparam logic [LW-1:0] LEN_MAX = LW'(PAT_W);

  state_t            state, state_nxt;
  logic [PAT_W-1:0]  hist, hist_nxt, shift_h, pattern, mask;
  logic [LW-1:0]     len, fill, fill_nxt, fill_inc;
  logic              overlap, cfg_ok, step, full, hit, z_d, err_d;

  assign cfg_ok   = (cfg_len >= LEN_MIN) && (cfg_len <= LEN_MAX);
  // A load takes precedence over the sample in the same cycle.
  assign step     = ena && (state != S_IDLE) && !cfg_load;
  assign shift_h  = {hist[PAT_W-2:0], sig_to_test};
  assign fill_inc = (fill == len) ? fill : fill + LW'(1);
  assign full     = (fill_inc == len);
  assign mask     = ~({PAT_W{1'b1}} << len);
  // Compare includes the bit being shifted in this cycle.
  assign hit      = step && full && (((shift_h ^ pattern) & mask) == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (cfg_load)            state_nxt = cfg_ok ? S_FILL : S_IDLE;
    else if (step) begin
      if (hit && !overlap)   state_nxt = S_FILL;
      else if (full)         state_nxt = S_MATCH;
      else                   state_nxt = S_FILL;
    end
  end

  // Output / datapath next values
  always_comb begin
    hist_nxt = hist;
    fill_nxt = fill;
    z_d      = hit;
    err_d    = cfg_load && !cfg_ok;
    if (cfg_load) begin
      if (cfg_ok) begin
        hist_nxt = '0;
        fill_nxt = '0;
      end
    end else if (step) begin
      if (hit && !overlap) begin
        hist_nxt = '0;
        fill_nxt = '0;
      end else begin
        hist_nxt = shift_h;
        fill_nxt = fill_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist    <= '0;
      fill    <= '0;
      pattern <= '0;
      len     <= '0;
      overlap <= 1'b1;
      z       <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      hist    <= hist_nxt;
      fill    <= fill_nxt;
      z       <= z_d;
      cfg_err <= err_d;
      // A rejected load leaves the previous configuration in place.
      if (cfg_load && cfg_ok) begin
        pattern <= cfg_pattern;
        len     <= cfg_len;
        overlap <= cfg_overlap;
      end
    end
  end

  // BCD match counter
  logic [DIGITS-1:0][3:0] cnt, cnt_inc;
  logic                   wrap;

  always_comb begin : p_bcd_inc
    logic carry;
    carry   = 1'b1;
    cnt_inc = cnt;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (cnt[i] == 4'd9) cnt_inc[i] = 4'd0;
        else begin
          cnt_inc[i] = cnt[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_count) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (hit) begin
      cnt <= cnt_inc;
      if (wrap) ovf <= 1'b1;
    end
  end

  assign count = cnt;

  // Display: one decoder per digit, registered once.
  logic [DIGITS-1:0][6:0] seg_raw, disp_nxt, disp_q;
  logic [DIGITS-1:0]      blank;

  always_comb begin
    blank = '0;
`ifdef SEQ_DET_BLANK_EN
    begin : p_lead
      logic lead;
      lead = 1'b1;
      for (int i = DIGITS-1; i > 0; i--) begin
        if (lead && cnt[i] == 4'd0) blank[i] = 1'b1;
        else                        lead     = 1'b0;
      end
    end
`endif
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg7_decode u_dec (.bcd(cnt[g]), .seg(seg_raw[g]));
    assign disp_nxt[g] = blank[g] ? SEG_BLANK : seg_raw[g];
  end

  always_ff @(posedge clk) begin
    if (rst) disp_q <= {DIGITS{SEG_0}};
    else     disp_q <= disp_nxt;
  end

  assign disp = disp_q;

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;
  localparam int PAT_W  = 8;
  localparam int DIGITS = 2;
  localparam int LW     = $clog2(PAT_W+1);
  localparam int MAXC   = 10**DIGITS;
  localparam logic [6:0] SEGT [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000};

  logic clk = 1'b0;
  logic rst = 1'b1, ena = 1'b0, sig_to_test = 1'b0, cfg_load = 1'b0;
  logic cfg_overlap = 1'b0, clr_count = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LW-1:0] cfg_len = '0;
  logic z, cfg_err, ovf;
  logic [4*DIGITS-1:0] count;
  logic [7*DIGITS-1:0] disp;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(PAT_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .ena(ena), .sig_to_test(sig_to_test),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clr_count(clr_count), .z(z),
    .cfg_err(cfg_err), .count(count), .ovf(ovf), .disp(disp));

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit               m_on;
  logic [PAT_W-1:0] m_pat;
  int               m_len;
  bit               m_ovl;
  bit               hq[$];      // bits received since the last flush, oldest first
  int               cnt_e;      // match count as a plain integer
  bit               ovf_e, z_e, err_e;
  logic [7*DIGITS-1:0] disp_e;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int c);
    logic [4*DIGITS-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((c / (10**i)) % 10);
    return r;
  endfunction

  function automatic logic [7*DIGITS-1:0] disp_of(input int c);
    logic [7*DIGITS-1:0] r;
    int d;
`ifdef SEQ_DET_BLANK_EN
    bit lead;
    lead = 1'b1;
`endif
    for (int i = DIGITS-1; i >= 0; i--) begin
      d = (c / (10**i)) % 10;
      r[7*i +: 7] = SEGT[d];
`ifdef SEQ_DET_BLANK_EN
      if (i > 0 && lead && d == 0) r[7*i +: 7] = 7'b1111111;
      else lead = 1'b0;
`endif
    end
    return r;
  endfunction

  // True when the newest m_len received bits spell the pattern (MSB first).
  function automatic bit tail_match();
    int n;
    n = hq.size();
    if (n < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (hq[n-m_len+k] != m_pat[m_len-1-k]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    disp_e = disp_of(cnt_e);
    if (rst) begin
      m_on = 0; m_pat = '0; m_len = 0; m_ovl = 1; hq.delete();
      cnt_e = 0; ovf_e = 0; z_e = 0; err_e = 0;
      disp_e = {DIGITS{7'b1000000}};
    end else begin
      z_e = 0; err_e = 0;
      if (cfg_load) begin
        if (int'(cfg_len) >= 2 && int'(cfg_len) <= PAT_W) begin
          m_on = 1; m_pat = cfg_pattern; m_len = int'(cfg_len);
          m_ovl = cfg_overlap; hq.delete();
        end else begin
          m_on = 0; err_e = 1;
        end
      end else if (ena && m_on) begin
        hq.push_back(sig_to_test);
        if (tail_match()) begin
          z_e = 1;
          if (!m_ovl) hq.delete();
        end
        while (hq.size() > 32) hq.delete(0);
      end
      if (clr_count) begin
        cnt_e = 0; ovf_e = 0;
      end else if (z_e) begin
        cnt_e = (cnt_e + 1) % MAXC;
        if (cnt_e == 0) ovf_e = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("z", z, z_e);
      check("cfg_err", cfg_err, err_e);
      check("count", count, to_bcd(cnt_e));
      check("ovf", ovf, ovf_e);
      check("disp", disp, disp_e);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit e, input bit s, output bit zz);
    ena = e; sig_to_test = s;
    @(negedge clk);
    zz = z;
  endtask

  task automatic load(input logic [PAT_W-1:0] p, input logic [LW-1:0] l, input bit o);
    cfg_load = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    ena = 1; sig_to_test = 1'($urandom);   // sample in the load cycle is discarded
    @(negedge clk);
    cfg_load = 0; ena = 0;
  endtask

  task automatic clr();
    clr_count = 1;
    @(negedge clk);
    clr_count = 0;
  endtask

  bit s6 [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  bit zz, zor;
  logic [5:0] zv;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_z", z, 1'b0);
    check("rst_err", cfg_err, 1'b0);
    check("rst_count", count, 8'h00);
    check("rst_ovf", ovf, 1'b0);
    check("rst_disp", disp, {7'b1000000, 7'b1000000});
    chk_en = 1;
    rst = 0;

    // overlap=1: matches after bits 4 and 6
    load(8'b0101, LW'(4), 1'b1);
    zv = '0;
    for (int i = 0; i < 6; i++) begin step(1, s6[i], zz); zv[i] = zz; end
    ena = 0;
    check("ovl1_z", zv, 6'b101000);
    check("ovl1_count", count, 8'h02);

    // overlap=0: match after bit 4 only
    clr();
    load(8'b0101, LW'(4), 1'b0);
    zv = '0;
    for (int i = 0; i < 6; i++) begin step(1, s6[i], zz); zv[i] = zz; end
    ena = 0;
    check("ovl0_z", zv, 6'b001000);
    check("ovl0_count", count, 8'h01);

    // ena toggled between pattern bits
    load(8'b0101, LW'(4), 1'b1);
    zv = '0; zor = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1'($urandom), zz); zor |= zz;
      step(1, s6[i], zz); zv[i] = zz;
    end
    step(0, 1'($urandom), zz); zor |= zz;
    check("ena_tog_z", zv[3:0], 4'b1000);
    check("ena_tog_idle_z", zor, 1'b0);
    check("ena_tog_count", count, 8'h02);

    // reset in the middle of a pattern, coinciding with load/clear/sample
    load(8'b0101, LW'(4), 1'b1);
    for (int i = 0; i < 3; i++) step(1, s6[i], zz);
    rst = 1; cfg_load = 1; cfg_pattern = 8'b0101; cfg_len = LW'(4);
    clr_count = 1; ena = 1; sig_to_test = 1;
    @(negedge clk);
    check("mid_rst_z", z, 1'b0);
    check("mid_rst_err", cfg_err, 1'b0);
    check("mid_rst_count", count, 8'h00);
    check("mid_rst_ovf", ovf, 1'b0);
    check("mid_rst_disp", disp, {7'b1000000, 7'b1000000});
    rst = 0; cfg_load = 0; clr_count = 0;
    zor = 0;
    step(1, 1'b1, zz); zor |= zz;
    for (int i = 0; i < 8; i++) begin step(1, s6[i%4], zz); zor |= zz; end
    ena = 0;
    check("post_rst_no_z", zor, 1'b0);

    // rejected lengths
    load(8'b0101, LW'(0), 1'b1);
    check("len0_err", cfg_err, 1'b1);
    zor = 0;
    for (int i = 0; i < 20; i++) begin step(1, s6[i%4], zz); zor |= zz; end
    check("len0_no_z", zor, 1'b0);
    check("len0_err_gone", cfg_err, 1'b0);
    load(8'b0101, LW'(PAT_W+1), 1'b1);
    check("lenmax_err", cfg_err, 1'b1);
    zor = 0;
    for (int i = 0; i < 20; i++) begin step(1, s6[i%4], zz); zor |= zz; end
    check("lenmax_no_z", zor, 1'b0);
    load(8'b0101, LW'(4), 1'b0);
    zv = '0;
    for (int i = 0; i < 4; i++) begin step(1, s6[i], zz); zv[i] = zz; end
    check("recover_z", zv[3:0], 4'b1000);

    // counter wrap after 100 matches
    clr();
    load(8'b11, LW'(2), 1'b1);
    for (int i = 0; i < 101; i++) step(1, 1'b1, zz);
    ena = 0;
    check("wrap_count", count, 8'h00);
    check("wrap_ovf", ovf, 1'b1);
    @(negedge clk);
    check("wrap_disp", disp, {7'b1000000, 7'b1000000});
    clr();
    check("clr_ovf", ovf, 1'b0);

    // randomized traffic against the model
    load(8'($urandom), LW'($urandom_range(2, 4)), 1'($urandom));
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 299) == 0);
      cfg_load    = ($urandom_range(0, 39) == 0);
      cfg_pattern = 8'($urandom);
      cfg_len     = ($urandom_range(0, 4) != 0) ? LW'($urandom_range(2, 4))
                                                : LW'($urandom_range(0, 15));
      cfg_overlap = 1'($urandom);
      clr_count   = ($urandom_range(0, 149) == 0);
      ena         = ($urandom_range(0, 3) != 0);
      sig_to_test = 1'($urandom);
      @(negedge clk);
    end
    rst = 0; cfg_load = 0; clr_count = 0; ena = 0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
